// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS coprocessor 0: SR, Cause, EPC, PRId with interrupt/exception request
// Sits beside the decoder; INT_REQ steers the PC mux to the exception vector.
module cp0_unit #(
  parameter logic [31:0] PRID     = 32'h4D495053,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] DIN,
  input  logic [29:0] PC,
  input  logic [5:0]  HWInt,
  input  logic        We,
  input  logic        EXLClr,
  input  logic        OpExp,
  output logic        INT_REQ,
  output logic [29:0] EPC,
  output logic [31:0] DOUT
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [29:0] epc_q;

  logic        int_hit;
  logic        exc_hit;
  logic        take;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_hit = ie & ~exl & (|(HWInt & im));
  assign exc_hit = OpExp & ~exl;
  // Requests are held off while reset is asserted so nothing is taken on release.
  assign take    = (int_hit | exc_hit) & ~reset;
  assign INT_REQ = take;

  assign wr_sr  = We & ~take & (A == REG_SR);
  assign wr_epc = We & ~take & (A == REG_EPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= SR_RESET[15:10];
      exl      <= SR_RESET[1];
      ie       <= SR_RESET[0];
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc_q    <= 30'd0;
    end else begin
      ip <= HWInt;
      if (take) begin
        exl      <= 1'b1;
        epc_q    <= PC;
        exc_code <= int_hit ? EXC_INT : EXC_RI;
      end else begin
        if (wr_sr) begin
          im  <= DIN[15:10];
          ie  <= DIN[0];
          // eret beats an mtc0 to SR for the EXL bit only.
          exl <= EXLClr ? 1'b0 : DIN[1];
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (wr_epc) begin
          epc_q <= DIN[31:2];
        end
      end
    end
  end

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {16'd0, ip, 3'd0, exc_code, 2'd0};
  assign EPC        = epc_q;

  always_comb begin
    DOUT = 32'd0;
    case (A)
      REG_SR:    DOUT = sr_word;
      REG_CAUSE: DOUT = cause_word;
      REG_EPC:   DOUT = {epc_q, 2'b00};
      REG_PRID:  DOUT = PRID;
      default:   DOUT = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed vector bench for cp0_unit
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIN;
  logic [29:0] PC;
  logic [5:0]  HWInt;
  logic        We;
  logic        EXLClr;
  logic        OpExp;
  logic        INT_REQ;
  logic [29:0] EPC;
  logic [31:0] DOUT;

  int checks;
  int failures;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] din;
    logic [29:0] pc;
    logic [5:0]  hw;
    logic        we;
    logic        clr;
    logic        op;
    logic        irq;
    logic [31:0] dout;
    logic [29:0] epc;
  } vec_t;

  vec_t vecs[$];

  cp0_unit dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .DIN    (DIN),
    .PC     (PC),
    .HWInt  (HWInt),
    .We     (We),
    .EXLClr (EXLClr),
    .OpExp  (OpExp),
    .INT_REQ(INT_REQ),
    .EPC    (EPC),
    .DOUT   (DOUT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] a, input logic [31:0] din, input logic [29:0] pc,
                     input logic [5:0] hw, input logic we, input logic clr, input logic op,
                     input logic irq, input logic [31:0] dout, input logic [29:0] epc);
    vec_t v;
    v.a = a; v.din = din; v.pc = pc; v.hw = hw; v.we = we; v.clr = clr; v.op = op;
    v.irq = irq; v.dout = dout; v.epc = epc;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset  = 1'b1;
    A      = 5'd0;
    DIN    = 32'd0;
    PC     = 30'd0;
    HWInt  = 6'd0;
    We     = 1'b0;
    EXLClr = 1'b0;
    OpExp  = 1'b0;

    // Cycle-by-cycle vectors; DOUT/EPC expectations are the state before each edge.
    //   a      din            pc          hw      we clr op  irq dout           epc
    add(5'd12, 32'h0000_0401, 30'h0,      6'h00, 1, 0, 0,  0, 32'h0000_0000, 30'h0);
    add(5'd12, 32'h0,         30'h0C05,   6'h01, 0, 0, 0,  1, 32'h0000_0401, 30'h0);
    add(5'd12, 32'h0,         30'h0010,   6'h01, 0, 0, 0,  0, 32'h0000_0403, 30'h0C05);
    add(5'd14, 32'h0,         30'h0011,   6'h01, 0, 0, 0,  0, 32'h0000_3014, 30'h0C05);
    add(5'd13, 32'h0,         30'h0012,   6'h01, 0, 0, 0,  0, 32'h0000_0400, 30'h0C05);
    add(5'd12, 32'h0,         30'h0013,   6'h01, 0, 1, 0,  0, 32'h0000_0403, 30'h0C05);
    add(5'd12, 32'h0,         30'h0020,   6'h01, 0, 0, 0,  1, 32'h0000_0401, 30'h0C05);
    add(5'd12, 32'h0,         30'h0021,   6'h00, 0, 1, 0,  0, 32'h0000_0403, 30'h0020);
    add(5'd14, 32'h0000_1234, 30'h0055,   6'h01, 1, 0, 0,  1, 32'h0000_0080, 30'h0020);
    add(5'd14, 32'h0,         30'h0056,   6'h00, 0, 0, 0,  0, 32'h0000_0154, 30'h0055);
    add(5'd12, 32'h0000_0003, 30'h0057,   6'h00, 1, 1, 0,  0, 32'h0000_0403, 30'h0055);
    add(5'd12, 32'h0,         30'h0058,   6'h3F, 0, 0, 0,  0, 32'h0000_0001, 30'h0055);
    add(5'd13, 32'h0,         30'h0059,   6'h3F, 0, 0, 0,  0, 32'h0000_FC00, 30'h0055);
    add(5'd13, 32'hFFFF_FFFF, 30'h005A,   6'h3F, 1, 0, 0,  0, 32'h0000_FC00, 30'h0055);
    add(5'd13, 32'h0,         30'h005B,   6'h00, 0, 0, 0,  0, 32'h0000_FC00, 30'h0055);
    add(5'd7,  32'h0,         30'h005C,   6'h00, 0, 0, 0,  0, 32'h0000_0000, 30'h0055);
    add(5'd15, 32'h0,         30'h005D,   6'h00, 0, 0, 0,  0, 32'h4D49_5053, 30'h0055);
    add(5'd12, 32'h0,         30'h005E,   6'h00, 1, 0, 0,  0, 32'h0000_0001, 30'h0055);
    add(5'd12, 32'h0,         30'h0100,   6'h00, 0, 0, 1,  1, 32'h0000_0000, 30'h0055);
    add(5'd13, 32'h0,         30'h0200,   6'h00, 0, 0, 1,  0, 32'h0000_0028, 30'h0100);
    add(5'd14, 32'h0,         30'h0201,   6'h00, 0, 0, 0,  0, 32'h0000_0400, 30'h0100);
    add(5'd12, 32'h0,         30'h0202,   6'h00, 0, 0, 0,  0, 32'h0000_0002, 30'h0100);

    // Reset state, read while reset is held.
    #3;
    check("reset_irq", {31'd0, INT_REQ}, 32'd0);
    check("reset_epc", {2'd0, EPC}, 32'd0);
    for (int r = 12; r <= 15; r++) begin
      A = r[4:0];
      #1;
      check($sformatf("reset_dout_a%0d", r), DOUT, (r == 15) ? 32'h4D49_5053 : 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      A      = vecs[i].a;
      DIN    = vecs[i].din;
      PC     = vecs[i].pc;
      HWInt  = vecs[i].hw;
      We     = vecs[i].we;
      EXLClr = vecs[i].clr;
      OpExp  = vecs[i].op;
      #2;
      check($sformatf("v%0d_irq", i), {31'd0, INT_REQ}, {31'd0, vecs[i].irq});
      check($sformatf("v%0d_dout", i), DOUT, vecs[i].dout);
      check($sformatf("v%0d_epc", i), {2'd0, EPC}, {2'd0, vecs[i].epc});
    end

    // Mid-cycle reset while EXL=1: state clears immediately, pending OpExp dropped.
    @(negedge clk);
    A = 5'd12; We = 1'b0; EXLClr = 1'b0; HWInt = 6'd0; OpExp = 1'b1; PC = 30'h0300;
    #2;
    check("pre_reset_sr", DOUT, 32'h0000_0002);
    reset = 1'b1;
    #1;
    check("midrst_irq", {31'd0, INT_REQ}, 32'd0);
    check("midrst_sr", DOUT, 32'd0);
    check("midrst_epc", {2'd0, EPC}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("post_reset_irq", {31'd0, INT_REQ}, 32'd1);
    @(negedge clk);
    OpExp = 1'b0; A = 5'd14;
    #2;
    check("post_reset_epc", DOUT, 32'h0000_0C00);
    A = 5'd13;
    #1;
    check("post_reset_cause", DOUT, 32'h0000_0028);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
